// File: rtl/interpo_coef_seq_pkg.sv
// Shared definitions for the interpolator coefficient sequencer: default
// geometry, FSM state encoding and the circular address increment.
package interpo_coef_seq_pkg;

  localparam int unsigned DEF_DEPTH = 40;
  localparam int unsigned DEF_AW    = 6;
  localparam int unsigned DEF_DW    = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  function automatic int unsigned wrap_inc(input int unsigned a, input int unsigned depth);
    return (a + 1 >= depth) ? 0 : a + 1;
  endfunction

endpackage

// File: rtl/interpo_coef_seq_if.sv
// Coefficient stream (valid/ready with end-of-burst marker) between the
// sequencer and the interpolator datapath.
interface interpo_coef_seq_if
  import interpo_coef_seq_pkg::*;
#(
  parameter int unsigned DW = DEF_DW
);
  logic [DW-1:0] coef_data;
  logic          coef_valid;
  logic          coef_ready;
  logic          coef_last;

  modport master (output coef_data, output coef_valid, output coef_last, input coef_ready);
  modport slave  (input coef_data, input coef_valid, input coef_last, output coef_ready);
endinterface

// File: rtl/interpo_coef_skid.sv
// Two-entry FIFO holding captured RAM words; the head is presented
// directly on dout. Caller guarantees push only with room and pop only when non-empty.
module interpo_coef_skid #(
  parameter int unsigned W = 33
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty,
  output logic [1:0]   count
);
  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + 2'(push) - 2'(pop);
    end
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == 2'd2);
  assign empty = (count == 2'd0);
endmodule

// File: rtl/interpo_coef_seq.sv
// Streams a burst of coefficients from RAM port 2 into a valid/ready stream,
// issuing reads only while the 2-word skid FIFO can absorb the returning data.
module interpo_coef_seq
  import interpo_coef_seq_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_DEPTH,
  parameter int unsigned AW    = DEF_AW,
  parameter int unsigned DW    = DEF_DW
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [AW-1:0] tap_cnt,
  input  logic          abort,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [AW-1:0] ram_address,
  output logic          ram_chipselect,
  output logic          ram_write,
  input  logic [DW-1:0] ram_readdata,
  interpo_coef_seq_if.master coef
);
  state_t        state, state_nxt;
  logic [AW-1:0] rd_addr, rd_addr_nxt;
  logic [AW-1:0] rd_left, rd_left_nxt;
  logic [AW-1:0] addr_c;
  logic          inflight_vld, inflight_last;
  logic          start_ok, credit, issue, issue_last;
  logic          pop, push, flush, done_c, err_nxt;
  logic [2:0]    occ;
  logic [1:0]    fifo_count;
  logic          fifo_full, fifo_empty;
  logic [DW:0]   fifo_dout;
  logic          head_last;

  assign start_ok = (tap_cnt != '0) && (32'(tap_cnt) <= DEPTH) && (32'(base_addr) < DEPTH);
  assign pop      = coef.coef_valid & coef.coef_ready;
  // A word popped this cycle frees its slot in time for the read issued now.
  assign occ      = 3'(fifo_count) + 3'(inflight_vld) - 3'(pop);
  assign credit   = (occ < 3'd2);
  assign head_last = fifo_dout[DW];

  always_comb begin
    state_nxt   = state;
    rd_addr_nxt = rd_addr;
    rd_left_nxt = rd_left;
    addr_c      = '0;
    issue       = 1'b0;
    issue_last  = 1'b0;
    flush       = 1'b0;
    done_c      = 1'b0;
    err_nxt     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (start_ok) begin
            issue       = 1'b1;
            addr_c      = base_addr;
            issue_last  = (tap_cnt == AW'(1));
            rd_addr_nxt = AW'(wrap_inc(32'(base_addr), DEPTH));
            rd_left_nxt = tap_cnt - AW'(1);
            state_nxt   = RUN;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      RUN: begin
        if (abort) begin
          flush     = 1'b1;
          done_c    = 1'b1;
          state_nxt = IDLE;
        end else if (rd_left == '0) begin
          state_nxt = DRAIN;
        end else if (credit) begin
          issue       = 1'b1;
          addr_c      = rd_addr;
          issue_last  = (rd_left == AW'(1));
          rd_addr_nxt = AW'(wrap_inc(32'(rd_addr), DEPTH));
          rd_left_nxt = rd_left - AW'(1);
          if (rd_left == AW'(1)) state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (abort) begin
          flush     = 1'b1;
          done_c    = 1'b1;
          state_nxt = IDLE;
        end else if (pop && head_last) begin
          done_c    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state         <= IDLE;
      rd_addr       <= '0;
      rd_left       <= '0;
      inflight_vld  <= 1'b0;
      inflight_last <= 1'b0;
      err           <= 1'b0;
    end else begin
      state         <= state_nxt;
      rd_addr       <= rd_addr_nxt;
      rd_left       <= rd_left_nxt;
      inflight_vld  <= issue;
      inflight_last <= issue_last;
      err           <= err_nxt;
    end
  end

  assign push = inflight_vld & ~flush & (~fifo_full | pop);

  interpo_coef_skid #(.W(DW + 1)) u_skid (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .flush   (flush),
    .din     ({inflight_last, ram_readdata}),
    .dout    (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // Combinational RAM-side outputs are held quiet while reset is asserted.
  assign ram_chipselect  = issue & reset_n;
  assign ram_address     = reset_n ? addr_c : '0;
  assign ram_write       = 1'b0;
  assign done            = done_c & reset_n;
  assign busy            = (state != IDLE);
  assign coef.coef_valid = ~fifo_empty;
  assign coef.coef_data  = fifo_empty ? '0 : fifo_dout[DW-1:0];
  assign coef.coef_last  = ~fifo_empty & head_last;
endmodule

// File: tb/tb_interpo_coef_seq.sv
// Self-checking bench for interpo_coef_seq: table-driven bursts plus abort and
// reset sequences, with an address/data scoreboard fed by the stimulus.
module tb_interpo_coef_seq;
  localparam int DEPTH = 40;

  typedef struct {
    logic [5:0]  base;
    logic [5:0]  tap;
    int unsigned rdy_pct;
    bit          ok;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic        last;
  } exp_t;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [5:0]  base_addr;
  logic [5:0]  tap_cnt;
  logic        abort;
  logic        busy, done, err;
  logic [5:0]  ram_address;
  logic        ram_chipselect, ram_write;
  logic [31:0] ram_readdata;

  interpo_coef_seq_if #(.DW(32)) cif ();

  interpo_coef_seq #(.DEPTH(40), .AW(6), .DW(32)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .base_addr      (base_addr),
    .tap_cnt        (tap_cnt),
    .abort          (abort),
    .busy           (busy),
    .done           (done),
    .err            (err),
    .ram_address    (ram_address),
    .ram_chipselect (ram_chipselect),
    .ram_write      (ram_write),
    .ram_readdata   (ram_readdata),
    .coef           (cif.master)
  );

  logic [31:0] ram_mem [DEPTH];
  exp_t        exp_q[$];
  logic [5:0]  addr_q[$];
  vec_t        vecs[10];

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int rdy_pct = 100;
  int outstanding = 0;
  int done_cnt = 0;
  int n_xfer = 0;
  int first_cyc = 0;
  int last_cyc = 0;
  int start_cyc = 0;
  logic        prev_stall = 1'b0;
  logic        prev_abort = 1'b0;
  logic [31:0] prev_data = '0;
  logic        prev_last = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk)
    if (ram_chipselect)
      ram_readdata <= (ram_address < 6'd40) ? ram_mem[ram_address] : 32'hDEAD_BEEF;

  initial begin
    cif.coef_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1 cif.coef_ready = ($urandom_range(0, 99) < rdy_pct);
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!reset_n) begin
      prev_stall = 1'b0;
    end else begin
      if (ram_chipselect) begin
        if (addr_q.size() == 0) check("unexpected_read", 1, 0);
        else check("ram_address", ram_address, addr_q.pop_front());
        outstanding++;
      end
      if (prev_stall && !prev_abort) begin
        check("stall_valid", cif.coef_valid, 1);
        check("stall_data", cif.coef_data, prev_data);
        check("stall_last", cif.coef_last, prev_last);
      end
      if (cif.coef_valid && cif.coef_ready) begin
        exp_t e;
        if (exp_q.size() == 0) begin
          check("unexpected_word", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("coef_data", cif.coef_data, e.data);
          check("coef_last", cif.coef_last, e.last);
        end
        if (cif.coef_last) check("done_with_last", done, 1);
        if (n_xfer == 0) first_cyc = cyc;
        last_cyc = cyc;
        n_xfer++;
        outstanding--;
      end
      check("outstanding_le2", outstanding > 2, 0);
      if (done) done_cnt++;
      prev_stall = cif.coef_valid && !cif.coef_ready;
      prev_abort = abort;
      prev_data  = cif.coef_data;
      prev_last  = cif.coef_last;
    end
  end

  task automatic push_expect(input int base, input int tap);
    for (int k = 0; k < tap; k++) begin
      int a;
      a = (base + k) % DEPTH;
      addr_q.push_back(6'(a));
      exp_q.push_back('{ram_mem[a], (k == tap - 1)});
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_valid"}, cif.coef_valid, 0);
    check({tag, "_last"}, cif.coef_last, 0);
    check({tag, "_cs"}, ram_chipselect, 0);
    check({tag, "_addr"}, ram_address, 0);
    check({tag, "_data"}, cif.coef_data, 0);
    check({tag, "_ram_write"}, ram_write, 0);
  endtask

  // Entered and left at posedge+1.
  task automatic run_burst(input vec_t v, input bit with_abort);
    int d0;
    int t;
    rdy_pct   = v.rdy_pct;
    n_xfer    = 0;
    d0        = done_cnt;
    base_addr = v.base;
    tap_cnt   = v.tap;
    start     = 1'b1;
    abort     = with_abort;
    start_cyc = cyc;
    if (v.ok) push_expect(int'(v.base), int'(v.tap));
    @(negedge clk);
    check("err_start_cycle", err, 0);
    @(posedge clk);
    #1 start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    check("err_pulse", err, !v.ok);
    check("busy_after_start", busy, v.ok);
    if (!v.ok) begin
      repeat (3) begin
        @(negedge clk);
        check("err_single", err, 0);
        check("busy_rejected", busy, 0);
      end
      @(posedge clk);
      #1;
    end else begin
      t = 0;
      while (busy && t < 1000) begin
        @(posedge clk);
        #1 base_addr = 6'($urandom);
        tap_cnt = 6'($urandom);
        t++;
      end
      check("burst_timeout", t >= 1000, 0);
      check("done_count", done_cnt - d0, 1);
      check("word_count", n_xfer, v.tap);
      check("data_q_empty", exp_q.size(), 0);
      check("addr_q_empty", addr_q.size(), 0);
      if (v.rdy_pct == 100) begin
        check("first_valid_latency", first_cyc - start_cyc, 2);
        check("throughput", last_cyc - first_cyc, v.tap - 1);
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) ram_mem[i] = 32'h5A00_0000 ^ (i * 32'h0101_0107);
    vecs[0] = '{6'd0,  6'd40, 100, 1'b1};
    vecs[1] = '{6'd38, 6'd5,  100, 1'b1};
    vecs[2] = '{6'd0,  6'd0,  100, 1'b0};
    vecs[3] = '{6'd0,  6'd41, 100, 1'b0};
    vecs[4] = '{6'd40, 6'd1,  100, 1'b0};
    vecs[5] = '{6'd39, 6'd40, 100, 1'b1};
    vecs[6] = '{6'd10, 6'd7,  30,  1'b1};
    vecs[7] = '{6'd5,  6'd40, 30,  1'b1};
    vecs[8] = '{6'd0,  6'd1,  30,  1'b1};
    vecs[9] = '{6'd63, 6'd63, 100, 1'b0};

    reset_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    base_addr = '0;
    tap_cnt = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk);
    #1 reset_n = 1'b1;

    // Start is presented in the very first cycle after reset release.
    for (int i = 0; i < 10; i++) run_burst(vecs[i], 1'b0);

    // Abort in cycle 5 of a 40-word burst.
    rdy_pct = 100;
    base_addr = 6'd0;
    tap_cnt = 6'd40;
    start = 1'b1;
    push_expect(0, 40);
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    abort = 1'b1;
    @(negedge clk);
    check("abort_done", done, 1);
    check("abort_no_read", ram_chipselect, 0);
    @(posedge clk);
    #1 abort = 1'b0;
    exp_q.delete();
    addr_q.delete();
    outstanding = 0;
    @(negedge clk);
    check("abort_valid_off", cif.coef_valid, 0);
    check("abort_busy_off", busy, 0);
    check("abort_done_single", done, 0);
    @(posedge clk);
    #1 abort = 1'b1;
    @(negedge clk);
    check("idle_abort_done", done, 0);
    check("idle_abort_busy", busy, 0);
    @(posedge clk);
    #1 abort = 1'b0;
    run_burst('{6'd3, 6'd2, 100, 1'b1}, 1'b1);
    run_burst('{6'd12, 6'd6, 100, 1'b1}, 1'b0);

    // One-cycle reset in the middle of a stalled burst.
    rdy_pct = 30;
    base_addr = 6'd7;
    tap_cnt = 6'd40;
    start = 1'b1;
    push_expect(7, 40);
    @(posedge clk);
    #1 start = 1'b0;
    repeat (8) begin
      @(posedge clk);
      #1;
    end
    reset_n = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    exp_q.delete();
    addr_q.delete();
    outstanding = 0;
    @(negedge clk);
    check_all_zero("midreset");
    @(posedge clk);
    #1;
    run_burst('{6'd20, 6'd3, 100, 1'b1}, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
